wptr_full_ctrl: RTL
===================

# wptr_full_ctrl

Write-domain pointer and full-flag controller for the asynchronous FIFO. It brings the read-domain Gray pointer into the write clock domain through a two-flop synchronizer and converts it to binary. It also advances the write pointer on accepted writes and produces the Gray write pointer that the read domain synchronizes. It drives the memory write address/enable and the full, almost-full, level and overflow status seen by the producer.

## Interface
Parameters:
- PTR_WIDTH, default `WPTR_WIDTH (8): pointer width, including the wrap bit. FIFO depth is 2^(PTR_WIDTH-1) = 128.
- AF_THRESH, default 4: almost_full asserts when free entries are AF_THRESH or fewer.

Ports:
- wclk  in  1  write-domain clock; all state is on its rising edge.
- wrst_n  in  1  reset, asynchronous assert, active-low; clears all state.
- winc  in  1  producer write request.
- rptr_gray  in  PTR_WIDTH  read pointer, Gray-coded, asynchronous to wclk.
- wovf_clr  in  1  clears the sticky overflow flag.
- waddr  out  PTR_WIDTH-1  memory write address (low bits of the binary write pointer).
- wen  out  1  memory write enable = winc & ~wfull (combinational).
- wptr_gray  out  PTR_WIDTH  registered Gray write pointer, sent to the read domain.
- wfull  out  1  registered full flag.
- walmost_full  out  1  registered almost-full flag.
- wlevel  out  PTR_WIDTH  registered conservative occupancy, 0 to 128.
- wovf  out  1  sticky flag: a write was attempted while full.

## Operation
- Synchronizer: rptr_gray passes through two flops, sync1 then sync2; sync2 is rptr_s.
- Conversion: rbin_s = Gray-to-binary(rptr_s), MSB first, bin[i] = bin[i+1]^gray[i].
- Write pointer: wbin_next = wbin + wen, modulo 2^PTR_WIDTH. wgray_next = (wbin_next>>1)^wbin_next. Both are registered.
- Full: full_next = (wgray_next == {~rptr_s[MSB:MSB-1], rptr_s[MSB-2:0]}).
- Level: level_next = (wbin_next − rbin_s) mod 2^PTR_WIDTH.
- Almost full: walmost_full_next = (level_next ≥ 128 − AF_THRESH).
- Overflow: wovf is set by winc & wfull. wovf_clr clears it; set wins when both occur in the same cycle.
- Gating: a write is gated only by the registered wfull. A read release in the same cycle does not admit that write.
- Reset: all outputs go to 0 asynchronously, including waddr, wptr_gray, wfull, walmost_full, wlevel, wovf and both sync flops.
- Reset mid-stream: the pointer restarts at 0. The read side must be reset together with this block; there is no independent recovery.

## Timing
- wen is combinational from winc and registered wfull; the memory write happens on the same edge.
- wptr_gray, waddr, wfull, wlevel and walmost_full update on the edge that accepts a write. They are visible the following cycle.
- Full asserts in the cycle after the 128th unread write. A write in that cycle is rejected.
- Read-pointer change to flag update: 3 wclk. This is 2 for the synchronizer plus 1 for the flag register. wfull and wlevel are pessimistic during this window, never optimistic.
- wptr_gray changes by at most one bit per wclk.

## Structure
- parameters.vh holds `WPTR_WIDTH and the default depth and AF_THRESH constants. No new typedefs.
- Sub-module sync_2ff, a width-parameterized two-flop synchronizer with wclk and wrst_n. It is reused by the read-side controller.
- Conversion is done by an instance of the shared Gray-to-binary converter, not re-coded here.
- The remaining pointer, flag and overflow logic is flat in this module.

## Test plan
All scenarios use PTR_WIDTH=8 and AF_THRESH=4.
- Mid-stream reset: after 20 writes, drop wrst_n without a clock edge. All outputs go to 0 immediately; the first write after release has waddr=0.
- Fill: rptr_gray=0, winc high for 130 cycles. Exactly 128 wen pulses; wfull=1 after the 128th; wptr_gray=0xC0; wlevel=128; wovf=1 on the 129th attempt.
- Almost full: walmost_full goes 0→1 on the edge where wlevel becomes 124, and never before.
- Drain release: from full, set rptr_gray=0x01. wfull drops exactly 3 wclk later; wlevel=127; the next winc is accepted.
- Wrap: with rptr_gray=0x87 (bin 250) and the write pointer at 250, do 10 writes. wbin wraps to 4; wlevel=10; wfull stays 0.
- Same-cycle release: while full, assert winc in the same cycle that rptr_gray changes. The write is rejected, wovf sets, and wovf_clr in that cycle does not clear it.

Source files
------------

// File: rtl/wptr_full_ctrl_pkg.sv
// rtl/wptr_full_ctrl_pkg.sv - default pointer width, depth and almost-full threshold for the write-side controller
`ifndef WPTR_WIDTH
`define WPTR_WIDTH 8
`endif

package wptr_full_ctrl_pkg;
    localparam int WPTR_WIDTH_DEF = `WPTR_WIDTH;
    localparam int FIFO_DEPTH_DEF = 1 << (WPTR_WIDTH_DEF - 1);
    localparam int AF_THRESH_DEF  = 4;
endpackage

// File: rtl/wptr_full_ctrl_if.sv
// rtl/wptr_full_ctrl_if.sv - producer-side write request, memory write port and status flags
interface wptr_full_ctrl_if
    import wptr_full_ctrl_pkg::*;
#(
    parameter int PTR_WIDTH = WPTR_WIDTH_DEF
) ();
    logic                 winc;
    logic                 wovf_clr;
    logic [PTR_WIDTH-2:0] waddr;
    logic                 wen;
    logic                 wfull;
    logic                 walmost_full;
    logic [PTR_WIDTH-1:0] wlevel;
    logic                 wovf;

    modport master (
        output winc, wovf_clr,
        input  waddr, wen, wfull, walmost_full, wlevel, wovf
    );

    modport slave (
        input  winc, wovf_clr,
        output waddr, wen, wfull, walmost_full, wlevel, wovf
    );
endinterface

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - shared Gray-to-binary converter, MSB-first running XOR
module gray2bin #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    always_comb begin
        logic acc;
        acc = 1'b0;
        bin = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
    end
endmodule

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - width-parameterized two-flop synchronizer, shared by both FIFO pointer controllers
module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] sync1;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            sync1 <= '0;
            q     <= '0;
        end else begin
            sync1 <= d;
            q     <= sync1;
        end
    end
endmodule

// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - write-domain pointer, full/almost-full/level/overflow controller for the async FIFO
module wptr_full_ctrl
    import wptr_full_ctrl_pkg::*;
#(
    parameter int PTR_WIDTH = WPTR_WIDTH_DEF,
    parameter int AF_THRESH = AF_THRESH_DEF
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic [PTR_WIDTH-1:0] rptr_gray,
    output logic [PTR_WIDTH-1:0] wptr_gray,
    wptr_full_ctrl_if.slave      wif
);
    localparam logic [PTR_WIDTH-1:0] AF_LEVEL =
        PTR_WIDTH'((1 << (PTR_WIDTH - 1)) - AF_THRESH);

    logic [PTR_WIDTH-1:0] rptr_s;
    logic [PTR_WIDTH-1:0] rbin_s;
    logic [PTR_WIDTH-1:0] wbin;
    logic [PTR_WIDTH-1:0] wbin_next;
    logic [PTR_WIDTH-1:0] wgray_next;
    logic [PTR_WIDTH-1:0] level_next;
    logic                 full_next;
    logic                 af_next;

    sync_2ff #(.WIDTH(PTR_WIDTH)) u_rptr_sync (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .d      (rptr_gray),
        .q      (rptr_s)
    );

    gray2bin #(.WIDTH(PTR_WIDTH)) u_rptr_g2b (
        .gray (rptr_s),
        .bin  (rbin_s)
    );

    // Only the registered full flag gates a write; a same-cycle read release is seen 3 clocks later.
    assign wif.wen    = wif.winc & ~wif.wfull;
    assign wif.waddr  = wbin[PTR_WIDTH-2:0];

    assign wbin_next  = wbin + PTR_WIDTH'(wif.wen);
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;
    assign full_next  = (wgray_next == {~rptr_s[PTR_WIDTH-1 -: 2], rptr_s[PTR_WIDTH-3:0]});
    assign level_next = wbin_next - rbin_s;
    assign af_next    = (level_next >= AF_LEVEL);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin             <= '0;
            wptr_gray        <= '0;
            wif.wfull        <= 1'b0;
            wif.walmost_full <= 1'b0;
            wif.wlevel       <= '0;
            wif.wovf         <= 1'b0;
        end else begin
            wbin             <= wbin_next;
            wptr_gray        <= wgray_next;
            wif.wfull        <= full_next;
            wif.walmost_full <= af_next;
            wif.wlevel       <= level_next;
            if (wif.winc && wif.wfull) begin
                wif.wovf <= 1'b1;
            end else if (wif.wovf_clr) begin
                wif.wovf <= 1'b0;
            end
        end
    end
endmodule
